// File: rtl/adder_share_arb_if.sv
// Requester, response and adder-side signal bundle for adder_share_arb.
// slave = arbiter view, master = requesters/consumer/adder view.
interface adder_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_sub;

    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic                     add_sub;
    logic [WIDTH-1:0]         add_sum;
    logic                     add_ovfl;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_ovfl;

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  req_sub,
        output req_ready,
        output add_a,
        output add_b,
        output add_sub,
        input  add_sum,
        input  add_ovfl,
        output rsp_valid,
        input  rsp_ready,
        output rsp_id,
        output rsp_sum,
        output rsp_ovfl
    );

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output req_sub,
        input  req_ready,
        input  add_a,
        input  add_b,
        input  add_sub,
        output add_sum,
        output add_ovfl,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_id,
        input  rsp_sum,
        input  rsp_ovfl
    );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin sharing of one saturating adder among NUM_REQ requesters.
// Define ADDER_ARB_B2B_EN to grant back-to-back straight out of RESP.
module adder_share_arb #(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 16,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_share_arb_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_add_sub;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_sum;
    logic             r_rsp_ovfl;

    logic [IDW-1:0]     w_id_next;
    logic [IDW-1:0]     w_base;
    logic [IDW-1:0]     w_win;
    logic               w_found;
    logic               w_accept;
    logic               w_grant;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic               w_sel_sub;
    logic [NUM_REQ-1:0] w_ready;

    assign w_id_next = (r_id == IDW'(NUM_REQ - 1))
                     ? '0
                     : r_id + IDW'(1);

    assign w_accept = (r_state == S_RESP)
                    && r_rsp_valid
                    && bus.rsp_ready;

`ifdef ADDER_ARB_B2B_EN
    // In RESP the pointer has not moved yet, so scan from past the owner
    assign w_base  = (r_state == S_RESP) ? w_id_next : r_ptr;
    assign w_grant = rst_n && w_found
                   && ((r_state == S_IDLE) || w_accept);
`else
    assign w_base  = r_ptr;
    assign w_grant = rst_n && w_found
                   && (r_state == S_IDLE);
`endif

    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(w_base) + k) % NUM_REQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_sel_a   = bus.req_a[i*WIDTH +: WIDTH];
                w_sel_b   = bus.req_b[i*WIDTH +: WIDTH];
                w_sel_sub = bus.req_sub[i];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = w_grant && (w_win == IDW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_sub   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_ovfl  <= 1'b0;
        end else begin
            // Operand regs only move on a grant, keeping the adder quiet
            if (w_grant) begin
                r_add_a   <= w_sel_a;
                r_add_b   <= w_sel_b;
                r_add_sub <= w_sel_sub;
                r_id      <= w_win;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_sum   <= bus.add_sum;
                    r_rsp_ovfl  <= bus.add_ovfl;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (w_accept) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= w_id_next;
                        r_state     <= w_grant ? S_EXEC : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.add_sub   = r_add_sub;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_ovfl  = r_rsp_ovfl;

    a_grant_onehot: assert property (
        @(posedge clk) disable iff (!rst_n)
        $onehot0(w_ready)
    );

    a_rsp_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_rsp_valid && !bus.rsp_ready)
        |=> (r_rsp_valid
             && $stable(r_rsp_sum)
             && $stable(r_rsp_id)
             && $stable(r_rsp_ovfl))
    );

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb with a saturating adder model.
// Build with ADDER_ARB_B2B_EN to match the back-to-back variant.
module tb_adder_share_arb;

    localparam int N = 4;
    localparam int W = 16;
`ifdef ADDER_ARB_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif
    localparam int SPACING = B2B ? 2 : 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    adder_share_arb_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    adder_share_arb #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Signed saturating adder standing in for the shared instance
    always_comb begin
        logic [W:0] ext;
        logic       ov;
        if (bus.add_sub)
            ext = {bus.add_a[W-1], bus.add_a} - {bus.add_b[W-1], bus.add_b};
        else
            ext = {bus.add_a[W-1], bus.add_a} + {bus.add_b[W-1], bus.add_b};
        ov           = ext[W] ^ ext[W-1];
        bus.add_ovfl = ov;
        bus.add_sum  = ov ? (ext[W] ? 16'h8000 : 16'h7FFF) : ext[W-1:0];
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic s);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_sub[i]      = s;
    endtask

    task automatic single_op(input string tag,
                             input int id,
                             input logic [W-1:0] a,
                             input logic [W-1:0] b,
                             input logic s,
                             input logic [W-1:0] exp_sum,
                             input logic exp_ovfl);
        set_op(id, a, b, s);
        bus.req_valid = 4'(1 << id);
        #1;
        check({tag, "_ready"}, bus.req_ready, 1 << id);
        tick();
        bus.req_valid = '0;
        #1;
        check({tag, "_exec_valid"}, bus.rsp_valid, 0);
        tick();
        check({tag, "_valid"}, bus.rsp_valid, 1);
        check({tag, "_sum"}, bus.rsp_sum, exp_sum);
        check({tag, "_ovfl"}, bus.rsp_ovfl, exp_ovfl);
        check({tag, "_id"}, bus.rsp_id, id);
        tick();
        check({tag, "_done"}, bus.rsp_valid, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_add_a"}, bus.add_a, 0);
        check({tag, "_add_b"}, bus.add_b, 0);
        check({tag, "_add_sub"}, bus.add_sub, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_id"}, bus.rsp_id, 0);
        check({tag, "_rsp_sum"}, bus.rsp_sum, 0);
        check({tag, "_rsp_ovfl"}, bus.rsp_ovfl, 0);
    endtask

    initial begin
        int order [5];
        int g;
        int r;
        int last;
        int wcyc;

        order = '{0, 1, 2, 3, 0};
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check_zero("rst");
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;

        single_op("add", 0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        single_op("sub", 2, 16'h1234, 16'h0212, 1'b1, 16'h1022, 1'b0);
        single_op("satp", 1, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1);
        single_op("satn", 3, 16'h8000, 16'h8001, 1'b0, 16'h8000, 1'b1);
        check("hold_a", bus.add_a, 16'h8000);
        check("hold_b", bus.add_b, 16'h8001);

        for (int i = 0; i < N; i++)
            set_op(i, 16'(i * 256), 16'h0001, 1'b0);
        bus.req_valid = 4'hF;
        g    = 0;
        r    = 0;
        last = 0;
        for (int c = 0; c < 40 && r < 5; c++) begin
            if (g >= 5) bus.req_valid = '0;
            #1;
            if (bus.req_ready != 0) begin
                check("rr_onehot", $countones(bus.req_ready), 1);
                if (g < 5) check("rr_grant", bus.req_ready, 1 << order[g]);
                if (g > 0) check("rr_spacing", c - last, SPACING);
                last = c;
                g++;
            end
            if (bus.rsp_valid) begin
                check("rr_rsp_id", bus.rsp_id, order[r]);
                check("rr_rsp_sum", bus.rsp_sum, order[r] * 256 + 1);
                r++;
            end
            tick();
        end
        check("rr_grants", g, 5);
        check("rr_rsps", r, 5);

        bus.rsp_ready = 1'b0;
        set_op(1, 16'h0010, 16'h0005, 1'b1);
        set_op(2, 16'h0003, 16'h0004, 1'b0);
        bus.req_valid = 4'b0010;
        #1;
        check("stall_grant", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0100;
        #1;
        check("stall_exec_ready", bus.req_ready, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_sum", bus.rsp_sum, 16'h000B);
            check("stall_id", bus.rsp_id, 1);
            check("stall_ready", bus.req_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("rel_valid", bus.rsp_valid, 1);
        check("rel_sum", bus.rsp_sum, 16'h000B);
        wcyc = 0;
        while (bus.req_ready == 0 && wcyc < 4) begin
            tick();
            #1;
            wcyc++;
        end
        check("rel_grant_delay", wcyc, B2B ? 0 : 1);
        check("rel_grant", bus.req_ready, 4'b0100);

        tick();
        bus.req_valid = '0;
        #1;
        check("exec2_valid", bus.rsp_valid, 0);
        check("exec2_a", bus.add_a, 16'h0003);
        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        check_zero("mid_rst");
        tick();
        check("mid_rst_ready", bus.req_ready, 0);
        rst_n         = 1'b1;
        bus.req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_valid", bus.rsp_valid, 0);
        end
        set_op(0, 16'h0100, 16'h0001, 1'b1);
        bus.req_valid = 4'hF;
        #1;
        check("post_rst_grant", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        tick();
        check("post_rst_rsp_valid", bus.rsp_valid, 1);
        check("post_rst_rsp_id", bus.rsp_id, 0);
        check("post_rst_rsp_sum", bus.rsp_sum, 16'h00FF);
        tick();
        check("post_rst_done", bus.rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
